// File: rtl/uart_loopback.sv
// uart_loopback: UART echo block for board bring-up and self-test.
// Every 8N1 byte (LSB first) received on UART_RXD is buffered in a small
// byte FIFO and retransmitted unchanged, in order, on UART_TXD.
//
// Parameters:
//   CLK_FREQ   - sys_clk frequency in Hz
//   UART_BPS   - baud rate; CLK_FREQ/UART_BPS clocks per bit (must be >= 4)
//   FIFO_DEPTH - byte buffer depth, power of two, >= 2
// Ports:
//   sys_clk  - system clock, all logic on its rising edge
//   sys_rst  - asynchronous active-high reset
//   UART_RXD - serial input, idle high, asynchronous to sys_clk
//   UART_TXD - serial output, idle high (registered)
module uart_loopback #(
  parameter int CLK_FREQ   = 50000000,
  parameter int UART_BPS   = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic UART_RXD,
  output logic UART_TXD
);

  localparam int BPS_CNT = CLK_FREQ / UART_BPS;
  localparam int CW      = $clog2(BPS_CNT);
  localparam int AW      = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_MID  = CW'(BPS_CNT / 2);
  localparam logic [CW-1:0] CNT_LAST = CW'(BPS_CNT - 1);
  // TXD is registered one cycle behind the TX state, so the STOP state ends
  // one clock early; the following IDLE cycle supplies the last stop clock.
  localparam logic [CW-1:0] CNT_TX_STOP_LAST = CW'(BPS_CNT - 2);
  localparam logic [AW:0]   PTR_ONE  = {{AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} uart_state_t;

  // ---------------- RX input synchronizer and edge detect ----------------
  logic rx_meta_q, rxs_q, rxs_prev_q;
  logic fall_s;

  // Two-flop synchronizer plus one delay register for falling-edge detection.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      rx_meta_q  <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
    end else begin
      rx_meta_q  <= UART_RXD;
      rxs_q      <= rx_meta_q;
      rxs_prev_q <= rxs_q;
    end
  end

  assign fall_s = rxs_prev_q & ~rxs_q;

  // ---------------- RX FSM ----------------
  uart_state_t rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic          push_s;

  // RX state register.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      rx_state_q <= ST_IDLE;
      rx_cnt_q   <= CNT_ZERO;
      rx_bit_q   <= 3'd0;
      rx_shift_q <= 8'h00;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
    end
  end

  // RX next state: mid-bit sampling, byte assembly and push request.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    push_s     = 1'b0;
    case (rx_state_q)
      ST_IDLE: begin
        rx_cnt_d = CNT_ZERO;
        if (fall_s) begin
          rx_state_d = ST_START;
        end else begin
          rx_state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if ((rx_cnt_q == CNT_MID) && rxs_q) begin
          // Start bit gone by mid-bit: glitch, abandon quietly.
          rx_state_d = ST_IDLE;
          rx_cnt_d   = CNT_ZERO;
        end else if (rx_cnt_q == CNT_LAST) begin
          rx_state_d = ST_DATA;
          rx_cnt_d   = CNT_ZERO;
          rx_bit_d   = 3'd0;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
      ST_DATA: begin
        if (rx_cnt_q == CNT_MID) begin
          rx_shift_d = {rxs_q, rx_shift_q[7:1]};
        end else begin
          rx_shift_d = rx_shift_q;
        end
        if (rx_cnt_q == CNT_LAST) begin
          rx_cnt_d = CNT_ZERO;
          if (rx_bit_q == 3'd7) begin
            rx_state_d = ST_STOP;
          end else begin
            rx_bit_d = rx_bit_q + 3'd1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
      ST_STOP: begin
        // Leave at stop mid-bit so an immediately following start is caught.
        if (rx_cnt_q == CNT_MID) begin
          rx_state_d = ST_IDLE;
          rx_cnt_d   = CNT_ZERO;
          push_s     = rxs_q;  // low stop bit = framing error, drop byte
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
      default: begin
        rx_state_d = ST_IDLE;
        rx_cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // ---------------- Byte FIFO ----------------
  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic        empty_s, full_s, wr_en_s, rd_en_s;

  assign empty_s = (wr_ptr_q == rd_ptr_q);
  assign full_s  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign wr_en_s = push_s & ~full_s;

  // FIFO storage; contents need no reset since the pointers define validity.
  always_ff @(posedge sys_clk) begin
    if (wr_en_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= rx_shift_q;
    end
  end

  // FIFO pointers, one extra wrap bit for full/empty distinction.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      wr_ptr_q <= {(AW+1){1'b0}};
      rd_ptr_q <= {(AW+1){1'b0}};
    end else begin
      if (wr_en_s) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (rd_en_s) rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  // ---------------- TX FSM ----------------
  uart_state_t tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_shift_q, tx_shift_d;
  logic          txd_q, txd_d;

  // TX state register and registered serial output.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      tx_state_q <= ST_IDLE;
      tx_cnt_q   <= CNT_ZERO;
      tx_bit_q   <= 3'd0;
      tx_shift_q <= 8'h00;
      txd_q      <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      txd_q      <= txd_d;
    end
  end

  // TX next state: pop, then start/data/stop bits each BPS_CNT clocks on the line.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    txd_d      = 1'b1;
    rd_en_s    = 1'b0;
    case (tx_state_q)
      ST_IDLE: begin
        txd_d    = 1'b1;
        tx_cnt_d = CNT_ZERO;
        if (!empty_s) begin
          rd_en_s    = 1'b1;
          tx_shift_d = mem_q[rd_ptr_q[AW-1:0]];
          tx_state_d = ST_START;
        end else begin
          tx_state_d = ST_IDLE;
        end
      end
      ST_START: begin
        txd_d = 1'b0;
        if (tx_cnt_q == CNT_LAST) begin
          tx_state_d = ST_DATA;
          tx_cnt_d   = CNT_ZERO;
          tx_bit_d   = 3'd0;
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_ONE;
        end
      end
      ST_DATA: begin
        txd_d = tx_shift_q[0];
        if (tx_cnt_q == CNT_LAST) begin
          tx_cnt_d   = CNT_ZERO;
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          if (tx_bit_q == 3'd7) begin
            tx_state_d = ST_STOP;
          end else begin
            tx_bit_d = tx_bit_q + 3'd1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_ONE;
        end
      end
      ST_STOP: begin
        txd_d = 1'b1;
        if (tx_cnt_q == CNT_TX_STOP_LAST) begin
          tx_state_d = ST_IDLE;
          tx_cnt_d   = CNT_ZERO;
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_ONE;
        end
      end
      default: begin
        txd_d      = 1'b1;
        tx_state_d = ST_IDLE;
        tx_cnt_d   = CNT_ZERO;
      end
    endcase
  end

  assign UART_TXD = txd_q;

endmodule

// File: tb/tb_uart_loopback.sv
// Self-checking bench for uart_loopback at 16 clocks per bit.
// dut_a: FIFO_DEPTH=16 for the echo tests; dut_b: FIFO_DEPTH=2 driven with
// shortened stop bits so the receiver outpaces the transmitter and bytes drop.
module tb_uart_loopback;

  localparam int BIT = 16;

  logic clk = 1'b0;
  logic rst;
  logic drv;
  logic sel;
  logic rxd_a, rxd_b;
  logic txd_a, txd_b;
  int   cyc = 0;

  int n_pass = 0;
  int n_chk  = 0;

  logic [7:0] q_a[$];
  logic       s_a[$];
  logic [7:0] q_b[$];
  logic       s_b[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign rxd_a = sel ? 1'b1 : drv;
  assign rxd_b = sel ? drv : 1'b1;

  uart_loopback #(.CLK_FREQ(16), .UART_BPS(1), .FIFO_DEPTH(16)) dut_a (
    .sys_clk(clk), .sys_rst(rst), .UART_RXD(rxd_a), .UART_TXD(txd_a));

  uart_loopback #(.CLK_FREQ(16), .UART_BPS(1), .FIFO_DEPTH(2)) dut_b (
    .sys_clk(clk), .sys_rst(rst), .UART_RXD(rxd_b), .UART_TXD(txd_b));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Decode one frame from the chosen TX line; called on the negedge where the start bit is first seen.
  task automatic decode(input bit which, output logic [7:0] b, output logic stop_ok);
    b = 8'h00;
    repeat (BIT/2) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      repeat (BIT) @(negedge clk);
      b[i] = which ? txd_b : txd_a;
    end
    repeat (BIT) @(negedge clk);
    stop_ok = which ? txd_b : txd_a;
  endtask

  always begin : mon_a
    logic [7:0] b;
    logic s;
    @(negedge clk);
    if (!rst && txd_a === 1'b0) begin
      decode(1'b0, b, s);
      q_a.push_back(b);
      s_a.push_back(s);
    end
  end

  always begin : mon_b
    logic [7:0] b;
    logic s;
    @(negedge clk);
    if (!rst && txd_b === 1'b0) begin
      decode(1'b1, b, s);
      q_b.push_back(b);
      s_b.push_back(s);
    end
  end

  // Drive one 8N1 frame; the stop bit lasts stop_len clocks when high.
  task automatic send_byte(input bit which, input logic [7:0] b, input logic stopv, input int stop_len);
    sel = which;
    drv = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      drv = b[i];
      repeat (BIT) @(negedge clk);
    end
    drv = stopv;
    if (stopv) begin
      repeat (stop_len) @(negedge clk);
    end else begin
      repeat (BIT) @(negedge clk);
      drv = 1'b1;
      repeat (BIT) @(negedge clk);
    end
  endtask

  // Wait (bounded) until the chosen echo queue holds n bytes, then check the count.
  task automatic wait_q(input bit which, input int n, input int limit, input string name);
    int t = 0;
    while ((which ? q_b.size() : q_a.size()) < n && t < limit) begin
      @(negedge clk);
      t++;
    end
    check(name, which ? q_b.size() : q_a.size(), n);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stopv;
    logic       echo;
  } vec_t;

  initial begin
    vec_t       tbl[8];
    logic [7:0] hello[13];
    logic [7:0] sent_b[120];
    logic [9:0] frame;
    logic [7:0] got;
    int         k, t0, errs, n0, zeros, j;
    bit         found;

    tbl[0] = '{8'hA5, 1'b1, 1'b1};
    tbl[1] = '{8'h55, 1'b0, 1'b0};
    tbl[2] = '{8'h3C, 1'b1, 1'b1};
    tbl[3] = '{8'h00, 1'b1, 1'b1};
    tbl[4] = '{8'hFF, 1'b1, 1'b1};
    tbl[5] = '{8'h01, 1'b1, 1'b1};
    tbl[6] = '{8'h80, 1'b0, 1'b0};
    tbl[7] = '{8'hC3, 1'b1, 1'b1};
    hello = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20, 8'h57,
              8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21, 8'h0A};

    rst = 1'b1;
    drv = 1'b1;
    sel = 1'b0;
    repeat (3) @(negedge clk);
    check("reset txd_a", txd_a, 1'b1);
    check("reset txd_b", txd_b, 1'b1);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("idle txd_a", txd_a, 1'b1);
    check("idle queue empty", q_a.size(), 0);

    // Test 1: 0x48 exact line trace and start latency.
    frame = {1'b1, 8'h48, 1'b0};
    k = cyc + 1;
    fork
      send_byte(1'b0, 8'h48, 1'b1, BIT);
      begin
        t0 = 0;
        while (txd_a !== 1'b0 && t0 < 400) begin
          @(negedge clk);
          t0++;
        end
        check("t1 start latency", cyc, k + 157);
        errs = 0;
        for (int i = 0; i < 10 * BIT; i++) begin
          if (txd_a !== frame[i / BIT]) errs++;
          @(negedge clk);
        end
        check("t1 bit trace errors", errs, 0);
        check("t1 line idle after", txd_a, 1'b1);
      end
    join
    wait_q(1'b0, 1, 100, "t1 echo count");
    if (q_a.size() > 0) begin
      got = q_a.pop_front();
      check("t1 echo byte", got, 8'h48);
      check("t1 stop bit", s_a.pop_front(), 1'b1);
    end

    // Table: single frames, some with a low stop bit that must not echo.
    foreach (tbl[i]) begin
      n0 = q_a.size();
      send_byte(1'b0, tbl[i].data, tbl[i].stopv, BIT);
      if (tbl[i].echo) begin
        wait_q(1'b0, n0 + 1, 400, "tbl echo count");
        if (q_a.size() > n0) begin
          check("tbl echo byte", q_a.pop_front(), tbl[i].data);
          check("tbl stop bit", s_a.pop_front(), 1'b1);
        end
      end else begin
        repeat (400) @(negedge clk);
        check("tbl framing error dropped", q_a.size(), n0);
      end
    end

    // Test 3: 4-clock glitch must not start a frame; then a valid 0xA5.
    n0 = q_a.size();
    drv = 1'b0;
    repeat (4) @(negedge clk);
    drv = 1'b1;
    zeros = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (txd_a !== 1'b1) zeros++;
    end
    check("t3 glitch no tx activity", zeros, 0);
    check("t3 glitch no echo", q_a.size(), n0);
    send_byte(1'b0, 8'hA5, 1'b1, BIT);
    wait_q(1'b0, n0 + 1, 400, "t3 echo count");
    if (q_a.size() > n0) check("t3 echo byte", q_a.pop_front(), 8'hA5);
    void'(s_a.pop_front());

    // Test 2: "Hello World!\n" back to back.
    n0 = q_a.size();
    foreach (hello[i]) send_byte(1'b0, hello[i], 1'b1, BIT);
    wait_q(1'b0, n0 + 13, 800, "t2 echo count");
    foreach (hello[i]) begin
      if (q_a.size() > 0) begin
        check("t2 echo byte", q_a.pop_front(), hello[i]);
        check("t2 stop bit", s_a.pop_front(), 1'b1);
      end
    end

    // Test 5: reset during TX data bits of 0xFF.
    send_byte(1'b0, 8'hFF, 1'b1, BIT);
    repeat (40) @(negedge clk);
    rst = 1'b1;
    #1;
    check("t5 txd high on reset", txd_a, 1'b1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    zeros = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (txd_a !== 1'b1) zeros++;
    end
    check("t5 txd stays high", zeros, 0);
    q_a.delete();
    s_a.delete();
    send_byte(1'b0, 8'h12, 1'b1, BIT);
    wait_q(1'b0, 1, 400, "t5 echo count");
    if (q_a.size() > 0) check("t5 echo byte", q_a.pop_front(), 8'h12);

    // Test 6: depth-2 FIFO, RX frames 156 clocks vs TX 160: FIFO fills, later bytes drop.
    foreach (sent_b[i]) sent_b[i] = 8'(i * 37 + 11);
    foreach (sent_b[i]) send_byte(1'b1, sent_b[i], 1'b1, 12);
    repeat (1500) @(negedge clk);
    check("t6 echoes present", (q_b.size() > 0), 1'b1);
    if (q_b.size() > 0) check("t6 first byte", q_b[0], sent_b[0]);
    errs = 0;
    j = 0;
    foreach (q_b[i]) begin
      found = 1'b0;
      while (j < 120 && !found) begin
        if (sent_b[j] == q_b[i]) found = 1'b1;
        j++;
      end
      if (!found) errs++;
      if (s_b[i] !== 1'b1) errs++;
    end
    check("t6 in-order subset errors", errs, 0);
    check("t6 some bytes dropped", (q_b.size() < 120), 1'b1);
    check("t6 most bytes kept", (q_b.size() >= 110), 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
